fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction decoder/controller. Keeps the program counter, issues in-order word requests to instruction memory, buffers returned words in a small FIFO, and presents one instruction plus its PC per cycle to decode through a valid/ready handshake. Taken branches and jumps from execute redirect the PC; in-flight and buffered instructions are squashed.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset (word aligned)
- DEPTH, 2, instruction buffer entries and maximum outstanding-plus-buffered words (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (current PC)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance
- imem_rdata  in  32  response instruction word
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  32  redirect target
- instr  out  32  instruction to decoder (buffer head)
- instr_pc  out  32  PC of instr
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decoder consumes head this cycle
- fetch_fault  out  1  sticky: misaligned redirect target seen

## Operation
- States: FETCH (issuing), STALL (no credit), HALT (fault). Reset → FETCH.
- Credit: issue allowed when outstanding + count − (instr_valid & instr_ready) < DEPTH. FETCH↔STALL follows credit each cycle.
- imem_req = (state != HALT) & credit; combinational. imem_addr = pc register.
- Acceptance (imem_req & imem_ready): pc ← pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); outstanding +1.
- Response: outstanding −1; if discard > 0, word dropped and discard −1; else {imem_rdata, pc of that request} pushed to buffer tail. Per-request PC tracked in a DEPTH-entry in-order tag queue.
- Head pop on instr_valid & instr_ready.
- Redirect with redirect_pc[1:0] == 0: buffer flushed (count ← 0), pc ← redirect_pc, discard ← outstanding after this cycle's response/accept updates, tag queue cleared, state → FETCH. Request presented the same cycle is withdrawn, not counted; memory treats unaccepted requests as withdrawn.
- Redirect with misaligned target: same flush/discard, fetch_fault ← 1, state → HALT; imem_req held 0 and instr_valid 0 until rst. Responses still arriving are discarded.
- Priority: rst > redirect > response/pop/accept. Redirect wins over same-cycle rvalid (word dropped) and over same-cycle pop (head squashed regardless).
- Buffer never overflows: outstanding + count ≤ DEPTH always; assertion-worthy.

## Timing
- Reset values: imem_req 0 while rst, imem_addr RESET_PC, instr 0, instr_pc 0, instr_valid 0, fetch_fault 0, outstanding/count/discard 0.
- First request asserted in first cycle after rst deasserts.
- Latency: accept at cycle t, rvalid earliest t+1, instr_valid earliest t+2 (registered buffer, no bypass).
- Throughput: one instruction per cycle sustained with DEPTH=2, single-cycle memory, instr_ready held 1.
- Redirect at cycle t: instr_valid 0 at t+1; imem_addr = redirect_pc at t+1; first redirected instr_valid earliest t+3.
- rst asserted mid-operation: all state cleared immediately (async); post-reset responses from pre-reset requests are the memory's responsibility to suppress.

## Test plan
- Reset RESET_PC=32'h100, memory ready=1 latency 1, instr_ready=1 → instr_pc 0x100,0x104,0x108… valid from cycle 2, one per cycle, no bubbles.
- instr_ready=0 after first instruction → imem_req drops once outstanding+count=2; release → remaining words delivered in order, none lost or duplicated.
- Redirect to 0x200 with one request outstanding → that response dropped, instr_valid 0 next cycle, next delivered instr_pc 0x200.
- Redirect coincident with imem_rvalid and with instr_valid&instr_ready → returned word and head both squashed; next instr_pc = redirect_pc.
- Redirect to 0x202 → fetch_fault 1, imem_req and instr_valid stay 0 for 20 cycles; assert rst → fetch_fault 0, fetch resumes at RESET_PC.
- Redirect to 32'hFFFF_FFF8 → instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus
// the decoder-facing instruction handshake.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid,
      input  imem_ready, imem_rvalid, imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid,
      output imem_ready, imem_rvalid, imem_rdata, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order memory requests, a small
// instruction buffer toward decode, and redirect/squash handling.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   fetch_unit_if.master bus,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_STALL = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   logic [1:0]    state;
   logic [31:0]   pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] count;
   logic [CW-1:0] discard;
   logic [PW-1:0] buf_rd, buf_wr, tag_rd, tag_wr;
   logic [31:0]   buf_data [DEPTH];
   logic [31:0]   buf_pc   [DEPTH];
   logic [31:0]   tag_pc   [DEPTH];

   logic          pop, accept, resp, drop, push, credit, misaligned;
   logic [CW:0]   occupancy;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pop        = 1'b0;
      occupancy  = '0;
      credit     = 1'b0;
      accept     = 1'b0;
      drop       = 1'b0;
      push       = 1'b0;
      misaligned = redirect_pc[1:0] != 2'b00;
      resp       = bus.imem_rvalid;

      pop       = bus.instr_valid & bus.instr_ready;
      occupancy = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
      credit    = occupancy < DEPTH_W;
      // A request shown in a redirect cycle is withdrawn: never counted as accepted.
      accept    = bus.imem_req & bus.imem_ready & ~redirect;
      drop      = resp & (discard != '0);
      push      = resp & ~drop & ~redirect & (state != S_HALT);
   end

   assign bus.imem_req    = ~rst & (state != S_HALT) & credit;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = (count != '0) && (state != S_HALT);
   assign bus.instr       = bus.instr_valid ? buf_data[buf_rd] : 32'h0;
   assign bus.instr_pc    = bus.instr_valid ? buf_pc[buf_rd]   : 32'h0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         outstanding <= '0;
         count       <= '0;
         discard     <= '0;
         buf_rd      <= '0;
         buf_wr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         fetch_fault <= 1'b0;
      end else begin
         outstanding <= outstanding + CW'(accept) - CW'(resp);
         if (redirect && state != S_HALT) begin
            count   <= '0;
            buf_rd  <= '0;
            buf_wr  <= '0;
            tag_rd  <= '0;
            tag_wr  <= '0;
            // Everything still in flight after this edge belongs to the squashed path.
            discard <= outstanding - CW'(resp);
            if (misaligned) begin
               fetch_fault <= 1'b1;
               state       <= S_HALT;
            end else begin
               pc    <= redirect_pc;
               state <= S_FETCH;
            end
         end else begin
            if (drop)
               discard <= discard - CW'(1);
            if (accept) begin
               pc     <= pc + 32'd4;
               tag_wr <= tag_wr + PW'(1);
            end
            if (resp && !drop)
               tag_rd <= tag_rd + PW'(1);
            if (push)
               buf_wr <= buf_wr + PW'(1);
            if (pop)
               buf_rd <= buf_rd + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (state != S_HALT)
               state <= credit ? S_FETCH : S_STALL;
         end
      end
   end

   // NOTE: storage arrays carry no reset; their contents are only visible behind count/valid.
   always_ff @(posedge clk) begin
      if (accept)
         tag_pc[tag_wr] <= pc;
      if (push) begin
         buf_data[buf_wr] <= bus.imem_rdata;
         buf_pc[buf_wr]   <= tag_pc[tag_rd];
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, outstanding} + {1'b0, count}) <= DEPTH_W);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a behavioural PC-stream model
// predicts every delivered instruction; a bench memory answers requests in order.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          DEPTH    = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          mem_ready_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   exp_t        exp_q[$];
   pend_t       pend_q[$];
   logic [31:0] popped_pcs[$];
   logic [31:0] model_pc;
   logic        halted;
   logic        redir_prev;
   logic [31:0] wrap_exp [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // Bench memory: in-order responses at least one cycle after acceptance.
   always @(negedge clk) begin
      #1;
      if (rst) begin
         pend_q.delete();
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = 32'h0;
         bus.imem_ready  = 1'b0;
      end else begin
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
         end
         bus.imem_ready = ($urandom_range(99) < mem_ready_pct);
      end
   end

   // Monitor and reference model: expected stream is RESET_PC, +4, +4 ...,
   // restarted at each aligned redirect target with everything pending squashed.
   always @(negedge clk) begin
      exp_t e;
      logic pop;
      #2;
      if (rst) begin
         check("rst_imem_req",    bus.imem_req,    32'h0);
         check("rst_imem_addr",   bus.imem_addr,   RESET_PC);
         check("rst_instr",       bus.instr,       32'h0);
         check("rst_instr_pc",    bus.instr_pc,    32'h0);
         check("rst_instr_valid", bus.instr_valid, 32'h0);
         check("rst_fetch_fault", fetch_fault,     32'h0);
         exp_q.delete();
         model_pc   = RESET_PC;
         halted     = 1'b0;
         redir_prev = 1'b0;
      end else begin
         pop = bus.instr_valid & bus.instr_ready;
         if (redir_prev) begin
            check("post_redirect_valid", bus.instr_valid, 32'h0);
            if (!halted)
               check("post_redirect_addr", bus.imem_addr, model_pc);
         end
         check("fetch_fault", fetch_fault, {31'h0, halted});
         if (halted) begin
            check("halt_imem_req",    bus.imem_req,    32'h0);
            check("halt_instr_valid", bus.instr_valid, 32'h0);
         end
         if (pop && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_instr: got pc %h, expected no instruction", bus.instr_pc);
            end else begin
               e = exp_q.pop_front();
               check("instr_pc", bus.instr_pc, e.pc);
               check("instr",    bus.instr,    e.data);
            end
            popped_pcs.push_back(bus.instr_pc);
         end
         if (!redirect && !pop && exp_q.size() == DEPTH)
            check("no_credit_req", bus.imem_req, 32'h0);
         if (bus.imem_req && bus.imem_ready && !redirect) begin
            check("imem_addr", bus.imem_addr, model_pc);
            exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
            pend_q.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            model_pc = model_pc + 32'd4;
            check("occupancy_le_depth", 32'(exp_q.size() <= DEPTH), 32'h1);
         end
         if (redirect) begin
            exp_q.delete();
            if (redirect_pc[1:0] == 2'b00)
               model_pc = redirect_pc;
            else
               halted = 1'b1;
         end
         redir_prev = redirect;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_pops(input int n, input string name, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         #3;
         if (popped_pcs.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: got %0d instructions, expected %0d within 60 cycles", name, popped_pcs.size(), n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   initial begin
      logic ok;
      wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      bus.instr_ready = 1'b0;
      repeat (3) tick();

      // Release reset: first request immediately, first instruction two cycles later, no bubbles.
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) tick();
         #3;
         check("p1_instr_valid", bus.instr_valid, {31'h0, k >= 2});
         if (k == 0) check("p1_first_req", bus.imem_req, 32'h1);
      end

      // Decoder stalls: requests stop once the buffer plus in-flight words fill DEPTH.
      tick();
      bus.instr_ready = 1'b0;
      repeat (8) tick();
      #3;
      check("p2_req_low",     bus.imem_req,    32'h0);
      check("p2_valid_held",  bus.instr_valid, 32'h1);
      tick();
      bus.instr_ready = 1'b1;
      repeat (6) tick();

      // Redirect during a steady stream (coincident response and pop are squashed).
      tick();
      popped_pcs.delete();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      wait_pops(1, "p3_wait", ok);
      if (ok) check("p3_first_pc", popped_pcs[0], 32'h0000_0200);

      // Misaligned redirect halts until reset; reset resumes at RESET_PC.
      repeat (5) tick();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0202;
      tick();
      redirect = 1'b0;
      repeat (20) tick();
      #3;
      check("p4_fault_sticky", fetch_fault, 32'h1);
      tick();
      rst = 1'b1;
      #3;
      check("p4_fault_cleared", fetch_fault, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      popped_pcs.delete();
      wait_pops(1, "p4_wait", ok);
      if (ok) check("p4_resume_pc", popped_pcs[0], RESET_PC);

      // PC wraps from the top of the address space to zero.
      repeat (5) tick();
      popped_pcs.delete();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect = 1'b0;
      wait_pops(4, "p5_wait", ok);
      if (ok)
         for (int i = 0; i < 4; i++) check("p5_wrap_pc", popped_pcs[i], wrap_exp[i]);

      // Randomized traffic: variable latency, memory back-pressure, decoder stalls, redirects.
      lat_max = 3;
      mem_ready_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         tick();
         bus.instr_ready = ($urandom_range(99) < 60);
         redirect        = ($urandom_range(99) < 3);
         redirect_pc     = 32'($urandom_range(1023)) << 2;
      end
      tick();
      redirect = 1'b0;
      bus.instr_ready = 1'b1;
      mem_ready_pct = 0;
      repeat (20) tick();
      #3;
      check("drain_all_delivered", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
